// File: rtl/fir_pkg.sv
// Shared definitions for the block FIR filter wrappers: data widths, the
// sequencer state encoding and the result round/saturate conversion.
package fir_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int RESULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fir_state_e;

  // Round half up at bit (shift-1), arithmetic shift, clamp to the signed 16-bit range.
  function automatic logic [SAMPLE_WIDTH-1:0] round_sat(
    input logic [RESULT_WIDTH-1:0] r,
    input int unsigned             shift
  );
    logic signed [RESULT_WIDTH:0] ext;
    logic signed [RESULT_WIDTH:0] bias;
    logic signed [RESULT_WIDTH:0] t;
    logic [SAMPLE_WIDTH-1:0]      res;
    ext  = $signed({r[RESULT_WIDTH-1], r});
    bias = 33'sd1 <<< (shift - 32'd1);
    t    = (ext + bias) >>> shift;
    if (t > 33'sd32767) begin
      res = 16'h7FFF;
    end else if (t < -33'sd32768) begin
      res = 16'h8000;
    end else begin
      res = t[SAMPLE_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational conversion of one 32-bit filter accumulator into a rounded,
// saturated 16-bit output sample.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int unsigned SHIFT = 15
) (
  input  logic [RESULT_WIDTH-1:0] result_i,
  output logic [SAMPLE_WIDTH-1:0] sample_o
);

  assign sample_o = round_sat(result_i, SHIFT);

endmodule

// File: rtl/fir_block_sequencer.sv
// Initiator-side sequencer for the block FIR filter: collects input samples
// into a block, starts the filter, waits for done and serialises the results.
module fir_block_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned SAMPLES_NUM    = 4,
  parameter int unsigned SHIFT          = 15,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                                clkIn,
  input  logic                                nResetIn,
  input  logic [SAMPLE_WIDTH-1:0]             sampleIn,
  input  logic                                sampleValidIn,
  output logic                                sampleReadyOut,
  output logic                                firStartOut,
  output logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataOut,
  input  logic                                firBusyIn,
  input  logic                                firDoneIn,
  input  logic [RESULT_WIDTH*SAMPLES_NUM-1:0] firResultIn,
  output logic [SAMPLE_WIDTH-1:0]             resultOut,
  output logic                                resultValidOut,
  input  logic                                resultReadyIn,
  output logic                                errorOut
);

  localparam int DW = SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int RW = RESULT_WIDTH * SAMPLES_NUM;
  localparam int CW = $clog2(SAMPLES_NUM + 1);
  localparam int LW = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  fir_state_e              state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DW-1:0]           collect_q, collect_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [RW-1:0]           results_q, results_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic                    start_q, start_d;
  logic [SAMPLE_WIDTH-1:0] result_q, result_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;

  logic                    accept_s;
  logic [LW-1:0]           next_lane_s;
  logic [RESULT_WIDTH-1:0] conv_in_s;
  logic [SAMPLE_WIDTH-1:0] conv_out_s;

  assign sampleReadyOut = (count_q < CW'(SAMPLES_NUM));
  assign accept_s       = sampleValidIn && sampleReadyOut;

  // The single converter sees the MSB lane at capture time, otherwise the next lane to emit.
  assign next_lane_s = (lane_q == {LW{1'b0}}) ? {LW{1'b0}} : lane_q - LW'(1);
  assign conv_in_s   = (state_q == ST_WAIT) ? firResultIn[RW-1 -: RESULT_WIDTH]
                                            : results_q[next_lane_s*RESULT_WIDTH +: RESULT_WIDTH];

  fir_round_sat #(.SHIFT(SHIFT)) u_round_sat (
    .result_i (conv_in_s),
    .sample_o (conv_out_s)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    collect_d = collect_q;
    timer_d   = timer_q;
    results_d = results_q;
    lane_d    = lane_q;
    start_d   = 1'b0;
    result_d  = result_q;
    valid_d   = valid_q;
    error_d   = error_q;

    if (accept_s) begin
      collect_d                   = collect_q << SAMPLE_WIDTH;
      collect_d[SAMPLE_WIDTH-1:0] = sampleIn;
      count_d                     = count_q + CW'(1);
    end else begin
      collect_d = collect_q;
    end

    case (state_q)
      ST_IDLE: begin
        if ((count_q == CW'(SAMPLES_NUM)) && !firBusyIn) begin
          state_d = ST_FIRE;
          start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRE: begin
        count_d = {CW{1'b0}};
        timer_d = {TW{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (firDoneIn) begin
          results_d = firResultIn;
          lane_d    = LW'(SAMPLES_NUM - 1);
          result_d  = conv_out_s;
          valid_d   = 1'b1;
          state_d   = ST_DRAIN;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (valid_q && resultReadyIn) begin
          if (lane_q == {LW{1'b0}}) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            lane_d   = lane_q - LW'(1);
            result_d = conv_out_s;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q   <= ST_IDLE;
      count_q   <= {CW{1'b0}};
      collect_q <= {DW{1'b0}};
      timer_q   <= {TW{1'b0}};
      results_q <= {RW{1'b0}};
      lane_q    <= {LW{1'b0}};
      start_q   <= 1'b0;
      result_q  <= {SAMPLE_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      collect_q <= collect_d;
      timer_q   <= timer_d;
      results_q <= results_d;
      lane_q    <= lane_d;
      start_q   <= start_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign firStartOut    = start_q;
  assign firDataOut     = collect_q;
  assign resultOut      = result_q;
  assign resultValidOut = valid_q;
  assign errorOut       = error_q;

endmodule

// File: tb/tb_fir_block_sequencer.sv
// Directed bench for fir_block_sequencer with default parameters
// (SAMPLES_NUM=4, SHIFT=15, TIMEOUT_CYCLES=4096).
module tb_fir_block_sequencer;

  logic         clkIn = 1'b0;
  logic         nResetIn;
  logic [15:0]  sampleIn;
  logic         sampleValidIn;
  logic         sampleReadyOut;
  logic         firStartOut;
  logic [63:0]  firDataOut;
  logic         firBusyIn;
  logic         firDoneIn;
  logic [127:0] firResultIn;
  logic [15:0]  resultOut;
  logic         resultValidOut;
  logic         resultReadyIn;
  logic         errorOut;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int start_cnt = 0;

  logic [127:0] res_vec;
  logic [15:0]  exp_out [4];

  fir_block_sequencer dut (
    .clkIn          (clkIn),
    .nResetIn       (nResetIn),
    .sampleIn       (sampleIn),
    .sampleValidIn  (sampleValidIn),
    .sampleReadyOut (sampleReadyOut),
    .firStartOut    (firStartOut),
    .firDataOut     (firDataOut),
    .firBusyIn      (firBusyIn),
    .firDoneIn      (firDoneIn),
    .firResultIn    (firResultIn),
    .resultOut      (resultOut),
    .resultValidOut (resultValidOut),
    .resultReadyIn  (resultReadyIn),
    .errorOut       (errorOut)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) begin
    if (nResetIn && resultValidOut && resultReadyIn) hs_cnt <= hs_cnt + 1;
    if (nResetIn && firStartOut) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed_block(input int first);
    for (int k = 0; k < 4; k++) begin
      chk("ready_fill", 64'(sampleReadyOut), 64'd1);
      sampleIn      = 16'(first + k);
      sampleValidIn = 1'b1;
      @(negedge clkIn);
    end
    sampleValidIn = 1'b0;
  endtask

  initial begin
    res_vec    = {32'h0000_4000, 32'h3FFF_FFFF, 32'hC000_0000, 32'hFFFF_BFFF};
    exp_out[0] = 16'h0001;
    exp_out[1] = 16'h7FFF;
    exp_out[2] = 16'h8000;
    exp_out[3] = 16'hFFFF;

    nResetIn = 1'b0; sampleIn = 16'd0; sampleValidIn = 1'b0; firBusyIn = 1'b0;
    firDoneIn = 1'b0; firResultIn = 128'd0; resultReadyIn = 1'b0;
    repeat (2) @(negedge clkIn);
    chk("rst_ready", 64'(sampleReadyOut), 64'd1);
    chk("rst_start", 64'(firStartOut), 64'd0);
    chk("rst_data", firDataOut, 64'd0);
    chk("rst_result", 64'(resultOut), 64'd0);
    chk("rst_valid", 64'(resultValidOut), 64'd0);
    chk("rst_error", 64'(errorOut), 64'd0);
    nResetIn = 1'b1;

    // Block 1: fill, start pulse, stalled drain
    feed_block(1);
    chk("full_ready_low", 64'(sampleReadyOut), 64'd0);
    chk("no_early_start", 64'(firStartOut), 64'd0);
    @(negedge clkIn);
    chk("start1", 64'(firStartOut), 64'd1);
    chk("data1", firDataOut, 64'h0001_0002_0003_0004);
    chk("fire_ready_low", 64'(sampleReadyOut), 64'd0);
    @(negedge clkIn);
    chk("start1_end", 64'(firStartOut), 64'd0);
    chk("ready_after_fire", 64'(sampleReadyOut), 64'd1);
    firResultIn = res_vec; firDoneIn = 1'b1;
    @(negedge clkIn);
    firDoneIn = 1'b0;
    chk("valid_msb", 64'(resultValidOut), 64'd1);
    chk("out0", 64'(resultOut), 64'(exp_out[0]));
    @(negedge clkIn);
    chk("out0_hold", 64'(resultOut), 64'(exp_out[0]));
    for (int i = 1; i < 4; i++) begin
      resultReadyIn = 1'b1;
      @(negedge clkIn);
      chk("out_stall", 64'(resultOut), 64'(exp_out[i]));
      resultReadyIn = 1'b0;
      @(negedge clkIn);
      chk("out_hold", 64'(resultOut), 64'(exp_out[i]));
      chk("valid_hold", 64'(resultValidOut), 64'd1);
    end
    resultReadyIn = 1'b1;
    @(negedge clkIn);
    resultReadyIn = 1'b0;
    chk("drain_done", 64'(resultValidOut), 64'd0);
    chk("hs_count", 64'(hs_cnt), 64'd4);

    // Block 2: busy delays start, then no done -> timeout
    firBusyIn = 1'b1;
    feed_block(5);
    for (int i = 0; i < 10; i++) begin
      chk("busy_no_start", 64'(firStartOut), 64'd0);
      @(negedge clkIn);
    end
    firBusyIn = 1'b0;
    @(negedge clkIn);
    chk("start2", 64'(firStartOut), 64'd1);
    chk("data2", firDataOut, 64'h0005_0006_0007_0008);
    @(negedge clkIn);
    chk("start2_end", 64'(firStartOut), 64'd0);
    chk("start_count", 64'(start_cnt), 64'd2);
    repeat (4095) @(negedge clkIn);
    chk("no_error_yet", 64'(errorOut), 64'd0);
    @(negedge clkIn);
    chk("timeout_error", 64'(errorOut), 64'd1);
    firResultIn = res_vec; firDoneIn = 1'b1;
    @(negedge clkIn);
    firDoneIn = 1'b0;
    chk("stray_done", 64'(resultValidOut), 64'd0);
    @(negedge clkIn);
    chk("stray_done2", 64'(resultValidOut), 64'd0);
    chk("error_sticky", 64'(errorOut), 64'd1);

    // Block 3: reset during drain after two outputs
    feed_block(9);
    @(negedge clkIn);
    chk("start3", 64'(firStartOut), 64'd1);
    @(negedge clkIn);
    firDoneIn = 1'b1;
    @(negedge clkIn);
    firDoneIn = 1'b0;
    chk("b3_out0", 64'(resultOut), 64'(exp_out[0]));
    resultReadyIn = 1'b1;
    @(negedge clkIn);
    chk("b3_out1", 64'(resultOut), 64'(exp_out[1]));
    @(negedge clkIn);
    chk("b3_out2", 64'(resultOut), 64'(exp_out[2]));
    resultReadyIn = 1'b0;
    #1 nResetIn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(resultValidOut), 64'd0);
    chk("mid_rst_result", 64'(resultOut), 64'd0);
    chk("mid_rst_ready", 64'(sampleReadyOut), 64'd1);
    chk("mid_rst_error", 64'(errorOut), 64'd0);
    chk("mid_rst_data", firDataOut, 64'd0);
    @(negedge clkIn);
    nResetIn = 1'b1;

    // Block 4: fresh block, back-to-back drain
    feed_block(13);
    @(negedge clkIn);
    chk("start4", 64'(firStartOut), 64'd1);
    chk("data4", firDataOut, 64'h000D_000E_000F_0010);
    @(negedge clkIn);
    firDoneIn = 1'b1; resultReadyIn = 1'b1;
    @(negedge clkIn);
    firDoneIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b4_valid", 64'(resultValidOut), 64'd1);
      chk("b4_out", 64'(resultOut), 64'(exp_out[i]));
      @(negedge clkIn);
    end
    chk("b4_done", 64'(resultValidOut), 64'd0);
    chk("b4_error", 64'(errorOut), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
